// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data_mem arbiter slice.
// The FSM encoding matches the state values data_mem debug tooling expects.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_P0   = 2'b01;
  localparam logic [1:0] GNT_P1   = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-requester arbiter: a lone request wins outright; on a conflict either port 0 wins
// (fixed priority) or the port that was not granted last time wins.
module rr_arb2
  import data_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       fixed_prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_P0;
      2'b10:   gnt = GNT_P1;
      2'b11:   gnt = (fixed_prio || last_grant) ? GNT_P0 : GNT_P1;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data_mem between port 0 (CPU) and port 1 (DMA/debug).
// Each grant runs accept -> one-cycle memory strobe -> one-cycle response pulse.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              port_q, port_d;
  logic              last_grant_q, last_grant_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic [1:0]        gnt;
  logic [1:0]        accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO),
    .gnt        (gnt)
  );

  // New work is taken only in IDLE or RESP; reset masks ready before the state is known.
  always_comb begin
    accept = GNT_NONE;
    if (rst_n && (state_q == IDLE || state_q == RESP)) begin
      accept = gnt;
    end
  end

  assign req0_ready = accept[0];
  assign req1_ready = accept[1];

  always_comb begin
    sel_we    = accept[1] ? req1_we    : req0_we;
    sel_addr  = accept[1] ? req1_addr  : req0_addr;
    sel_wdata = accept[1] ? req1_wdata : req0_wdata;
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    port_d        = port_q;
    last_grant_d  = last_grant_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_rdata_d  = rsp0_rdata_q;
    rsp1_rdata_d  = rsp1_rdata_q;

    case (state_q)
      IDLE, RESP: begin
        if (accept != GNT_NONE) begin
          state_d       = ACCESS;
          port_d        = accept[1];
          last_grant_d  = accept[1];
          we_d          = sel_we;
          mem_read_d    = !sel_we;
          mem_write_d   = sel_we;
          mem_address_d = sel_addr;
          mem_wdata_d   = sel_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        // data_mem reads combinationally, so its output is stable by the closing edge.
        state_d = RESP;
        if (port_q) begin
          rsp1_valid_d = 1'b1;
          if (!we_q) rsp1_rdata_d = mem_rdata;
        end else begin
          rsp0_valid_d = 1'b1;
          if (!we_q) rsp0_rdata_d = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      port_q        <= 1'b0;
      last_grant_q  <= 1'b1;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_rdata_q  <= '0;
      rsp1_rdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      port_q        <= port_d;
      last_grant_q  <= last_grant_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_rdata_q  <= rsp0_rdata_d;
      rsp1_rdata_q  <= rsp1_rdata_d;
    end
  end

  // Reset asserted during ACCESS kills the strobe so the in-flight write never commits.
  assign mem_read    = mem_read_q & rst_n;
  assign mem_write   = mem_write_q & rst_n;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_rdata  = rsp0_rdata_q;
  assign rsp1_rdata  = rsp1_rdata_q;

endmodule
